ap_lut_sequencer: RTL and testbench
===================================

Name: ap_lut_sequencer

Overview:
- Bit-serial operation sequencer for the three-column associative processor (CAM columns A, B, C).
- Takes a 2-input truth table from the host and computes C = f(A, B) on every cell in parallel.
- Pre-clears column C, then for each bit runs compare/write passes only for truth-table minterms equal to 1.
- Sits between the host command interface and the CAM array. It owns the keys, masks, write vector and compare mode of the array while busy.

Parameters:
- WORD_SIZE, 8, bits per CAM cell.
- CELL_QUANT, 512, number of cells (rows) per column.
- CMP_LAT, 1, cycles from key/mask registered to tags_a/tags_b valid; range 1..3.

Ports:
- clka  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  single-cycle command strobe; accepted only in IDLE
- tt  in  4  truth table; result bit = tt[{b,a}]
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse in DONE
- cam_mode  out  1  1 = array under sequencer control
- key_a  out  WORD_SIZE  compare key, column A
- key_b  out  WORD_SIZE  compare key, column B
- mask_a  out  WORD_SIZE  compare mask, column A
- mask_b  out  WORD_SIZE  compare mask, column B
- mask_c  out  WORD_SIZE  write bit mask, column C
- data_c  out  WORD_SIZE  write data, column C
- wea_vec_c  out  CELL_QUANT  per-cell write enable, column C
- tags_a  in  CELL_QUANT  match tags from column A
- tags_b  in  CELL_QUANT  match tags from column B

Behaviour:
- Reset: rst is synchronous, active-high; clock is clka.
- Reset values: state IDLE, busy=0, done=0, cam_mode=0, keys=0, mask_a/b/c=all ones, data_c=0, wea_vec_c=0.
- rst mid-operation returns to IDLE next edge. No done pulse. Partial column C contents are left as they are.
- All outputs are registered.
- States: IDLE, CLEAR, COMPARE, WAIT, WRITE, DONE.
- IDLE:
  - On start: latch tt into tt_q, set bit index i=0, set pass p = lowest set bit of tt_q, go to CLEAR.
  - start while busy is ignored.
  - tt is sampled only at accepted start.
- CLEAR (1 cycle): cam_mode=1, mask_c=all ones, data_c=0, wea_vec_c=all ones.
  - If tt_q==0 → DONE; else → COMPARE.
- COMPARE (1 cycle): key_a={p[0]}<<i, key_b={p[1]}<<i, mask_a=mask_b=1<<i, wea_vec_c=0 → WAIT.
- WAIT: hold outputs for CMP_LAT cycles (counter) → WRITE.
- WRITE (1 cycle): wea_vec_c=tags_a & tags_b sampled this cycle, data_c=1<<i, mask_c=1<<i.
  - Next p = next set bit of tt_q above p. If one exists → COMPARE.
  - Else, if i==WORD_SIZE-1 → DONE.
  - Else i=i+1, p = lowest set bit → COMPARE.
- wea_vec_c is forced to 0 in every state other than CLEAR and WRITE.
- DONE (1 cycle): done=1, busy=1, cam_mode=0, masks=all ones, keys=0 → IDLE.
- busy cycle count = 2 + WORD_SIZE·popcount(tt)·(2+CMP_LAT).
- i counter width is clog2(WORD_SIZE)+1 and must not wrap before the DONE decision.

Decomposition:
- Shared package ap_pkg:
  - state enum.
  - truth-table constants: TT_AND=4'b1000, TT_OR=4'b1110, TT_XOR=4'b0110, TT_NAND=4'b0111, TT_NOR=4'b0001, TT_XNOR=4'b1001, TT_COPY_A=4'b1010.
  - clog2 function.
- Sub-module ap_pass_select: combinational. Given tt_q and current p, returns next set bit above p plus a valid flag, and the lowest set bit. Instantiated once.

Test Plan:
- Test setup: bench uses a behavioural 4-cell CAM model with CMP_LAT=1, A={0x0F,0xF0,0xAA,0x00}, B={0x33,0x0F,0x55,0x00}.
- OR: start, tt=TT_OR → C={0x3F,0xFF,0xFF,0x00}; busy high exactly 74 cycles; one done pulse.
- AND: tt=TT_AND → C={0x03,0x00,0x00,0x00}; busy 26 cycles. XOR → C={0x3C,0xFF,0xFF,0x00}.
- tt=4'b0000 with C preloaded 0xFF → C all 0x00; busy 2 cycles; single wea_vec_c all-ones cycle.
- start pulsed again at cycle 10 of an OR run → ignored; result and cycle count unchanged.
- rst at cycle 20 of an OR run → next cycle busy=0, done=0, masks all ones, wea_vec_c=0. A fresh OR start then completes correctly.
- NOR with CMP_LAT=3 → C={0xC0,0x00,0x00,0xFF}; busy 2+8·1·5=42 cycles; wea_vec_c zero during every WAIT cycle.

Source files
------------

// File: rtl/ap_pkg.sv
// Shared types and constants for the associative-processor LUT sequencer.
package ap_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StCompare,
    StWait,
    StWrite,
    StDone
  } state_e;

  // Truth tables are indexed by {b, a}.
  localparam logic [3:0] TT_AND    = 4'b1000;
  localparam logic [3:0] TT_OR     = 4'b1110;
  localparam logic [3:0] TT_XOR    = 4'b0110;
  localparam logic [3:0] TT_NAND   = 4'b0111;
  localparam logic [3:0] TT_NOR    = 4'b0001;
  localparam logic [3:0] TT_XNOR   = 4'b1001;
  localparam logic [3:0] TT_COPY_A = 4'b1010;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned k = 0; k < 32; k++) begin
      if ((32'd1 << k) < value) res = k + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/ap_pass_select.sv
// Picks minterm passes: the next set truth-table bit above p, and the lowest set bit.
module ap_pass_select (
  input  logic [3:0] tt_i,
  input  logic [1:0] p_i,
  output logic [1:0] next_p_o,
  output logic       next_valid_o,
  output logic [1:0] low_p_o
);

  always_comb begin
    next_p_o     = p_i;
    next_valid_o = 1'b0;
    low_p_o      = 2'd0;
    // Walk downwards so the lowest qualifying bit is the last one assigned.
    for (int k = 3; k >= 0; k--) begin
      if (tt_i[k]) begin
        low_p_o = 2'(k);
        if (k > int'(p_i)) begin
          next_p_o     = 2'(k);
          next_valid_o = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ap_lut_sequencer.sv
// Bit-serial sequencer computing C = f(A, B) across all CAM cells from a 2-input truth table.
module ap_lut_sequencer
  import ap_pkg::*;
#(
  parameter int unsigned WORD_SIZE  = 8,
  parameter int unsigned CELL_QUANT = 512,
  parameter int unsigned CMP_LAT    = 1
) (
  input  logic                  clka,
  input  logic                  rst,
  input  logic                  start,
  input  logic [3:0]            tt,
  output logic                  busy,
  output logic                  done,
  output logic                  cam_mode,
  output logic [WORD_SIZE-1:0]  key_a,
  output logic [WORD_SIZE-1:0]  key_b,
  output logic [WORD_SIZE-1:0]  mask_a,
  output logic [WORD_SIZE-1:0]  mask_b,
  output logic [WORD_SIZE-1:0]  mask_c,
  output logic [WORD_SIZE-1:0]  data_c,
  output logic [CELL_QUANT-1:0] wea_vec_c,
  input  logic [CELL_QUANT-1:0] tags_a,
  input  logic [CELL_QUANT-1:0] tags_b
);

  localparam int unsigned IdxW = clog2(WORD_SIZE) + 1;
  localparam int unsigned CntW = (CMP_LAT > 1) ? clog2(CMP_LAT) : 1;

  state_e                state_q, state_d;
  logic [3:0]            tt_q, tt_d;
  logic [IdxW-1:0]       i_q, i_d;
  logic [1:0]            p_q, p_d;
  logic [CntW-1:0]       cnt_q, cnt_d;

  logic                  busy_q, busy_d, done_q, done_d, cam_mode_q, cam_mode_d;
  logic [WORD_SIZE-1:0]  key_a_q, key_a_d, key_b_q, key_b_d;
  logic [WORD_SIZE-1:0]  mask_a_q, mask_a_d, mask_b_q, mask_b_d;
  logic [WORD_SIZE-1:0]  mask_c_q, mask_c_d, data_c_q, data_c_d;
  logic [CELL_QUANT-1:0] wea_q, wea_d;

  logic [1:0]            next_p, low_p;
  logic                  next_valid;

  ap_pass_select u_pass_select (
    .tt_i         (tt_q),
    .p_i          (p_q),
    .next_p_o     (next_p),
    .next_valid_o (next_valid),
    .low_p_o      (low_p)
  );

  always_comb begin
    state_d = state_q;
    tt_d    = tt_q;
    i_d     = i_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          tt_d    = tt;
          i_d     = '0;
          state_d = StClear;
        end
      end
      StClear: begin
        p_d     = low_p;
        state_d = (tt_q == 4'd0) ? StDone : StCompare;
      end
      StCompare: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        if (cnt_q == CntW'(CMP_LAT - 1)) state_d = StWrite;
        else                             cnt_d   = cnt_q + 1'b1;
      end
      StWrite: begin
        if (next_valid) begin
          p_d     = next_p;
          state_d = StCompare;
        end else if (i_q == IdxW'(WORD_SIZE - 1)) begin
          state_d = StDone;
        end else begin
          i_d     = i_q + 1'b1;
          p_d     = low_p;
          state_d = StCompare;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are derived from the next state so every port comes straight from a flop.
  always_comb begin
    busy_d     = (state_d != StIdle);
    done_d     = (state_d == StDone);
    cam_mode_d = (state_d != StIdle) && (state_d != StDone);
    key_a_d    = key_a_q;
    key_b_d    = key_b_q;
    mask_a_d   = mask_a_q;
    mask_b_d   = mask_b_q;
    mask_c_d   = mask_c_q;
    data_c_d   = data_c_q;
    wea_d      = '0;
    unique case (state_d)
      StClear: begin
        mask_c_d = '1;
        data_c_d = '0;
        wea_d    = '1;
      end
      StCompare: begin
        key_a_d  = WORD_SIZE'(p_d[0]) << i_d;
        key_b_d  = WORD_SIZE'(p_d[1]) << i_d;
        mask_a_d = WORD_SIZE'(1) << i_d;
        mask_b_d = WORD_SIZE'(1) << i_d;
      end
      StWrite: begin
        wea_d    = tags_a & tags_b;
        data_c_d = WORD_SIZE'(1) << i_d;
        mask_c_d = WORD_SIZE'(1) << i_d;
      end
      StWait: ;
      default: begin
        key_a_d  = '0;
        key_b_d  = '0;
        mask_a_d = '1;
        mask_b_d = '1;
        mask_c_d = '1;
        data_c_d = '0;
      end
    endcase
  end

  always_ff @(posedge clka) begin
    if (rst) begin
      state_q    <= StIdle;
      tt_q       <= '0;
      i_q        <= '0;
      p_q        <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cam_mode_q <= 1'b0;
      key_a_q    <= '0;
      key_b_q    <= '0;
      mask_a_q   <= '1;
      mask_b_q   <= '1;
      mask_c_q   <= '1;
      data_c_q   <= '0;
      wea_q      <= '0;
    end else begin
      state_q    <= state_d;
      tt_q       <= tt_d;
      i_q        <= i_d;
      p_q        <= p_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cam_mode_q <= cam_mode_d;
      key_a_q    <= key_a_d;
      key_b_q    <= key_b_d;
      mask_a_q   <= mask_a_d;
      mask_b_q   <= mask_b_d;
      mask_c_q   <= mask_c_d;
      data_c_q   <= data_c_d;
      wea_q      <= wea_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign cam_mode  = cam_mode_q;
  assign key_a     = key_a_q;
  assign key_b     = key_b_q;
  assign mask_a    = mask_a_q;
  assign mask_b    = mask_b_q;
  assign mask_c    = mask_c_q;
  assign data_c    = data_c_q;
  assign wea_vec_c = wea_q;

endmodule

// File: tb/tb_ap_lut_sequencer.sv
// Scoreboard bench: two sequencers (compare latency 1 and 3) sharing a 4-cell CAM model.
module tb_ap_lut_sequencer;
  import ap_pkg::*;

  localparam int unsigned W = 8;
  localparam int unsigned N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic         start0 = 1'b0, start1 = 1'b0;
  logic [3:0]   tt = 4'd0;
  logic         sel = 1'b0;
  logic         preload = 1'b0;
  logic [W-1:0] preload_val = '0;

  logic         busy0, done0, cam_mode0, busy1, done1, cam_mode1;
  logic [W-1:0] key_a0, key_b0, mask_a0, mask_b0, mask_c0, data_c0;
  logic [W-1:0] key_a1, key_b1, mask_a1, mask_b1, mask_c1, data_c1;
  logic [N-1:0] wea0, wea1, tags_a, tags_b;

  ap_lut_sequencer #(.WORD_SIZE(W), .CELL_QUANT(N), .CMP_LAT(1)) u_dut0 (
    .clka(clk), .rst(rst), .start(start0), .tt(tt), .busy(busy0), .done(done0),
    .cam_mode(cam_mode0), .key_a(key_a0), .key_b(key_b0), .mask_a(mask_a0), .mask_b(mask_b0),
    .mask_c(mask_c0), .data_c(data_c0), .wea_vec_c(wea0), .tags_a(tags_a), .tags_b(tags_b)
  );

  ap_lut_sequencer #(.WORD_SIZE(W), .CELL_QUANT(N), .CMP_LAT(3)) u_dut1 (
    .clka(clk), .rst(rst), .start(start1), .tt(tt), .busy(busy1), .done(done1),
    .cam_mode(cam_mode1), .key_a(key_a1), .key_b(key_b1), .mask_a(mask_a1), .mask_b(mask_b1),
    .mask_c(mask_c1), .data_c(data_c1), .wea_vec_c(wea1), .tags_a(tags_a), .tags_b(tags_b)
  );

  logic         busy_m, done_m, cam_mode_m;
  logic [W-1:0] key_a_m, key_b_m, mask_a_m, mask_b_m, mask_c_m, data_c_m;
  logic [N-1:0] wea_m;
  assign busy_m     = sel ? busy1 : busy0;
  assign done_m     = sel ? done1 : done0;
  assign cam_mode_m = sel ? cam_mode1 : cam_mode0;
  assign key_a_m    = sel ? key_a1 : key_a0;
  assign key_b_m    = sel ? key_b1 : key_b0;
  assign mask_a_m   = sel ? mask_a1 : mask_a0;
  assign mask_b_m   = sel ? mask_b1 : mask_b0;
  assign mask_c_m   = sel ? mask_c1 : mask_c0;
  assign data_c_m   = sel ? data_c1 : data_c0;
  assign wea_m      = sel ? wea1 : wea0;

  // Behavioural CAM: masked compare piped by the selected latency, masked write into C.
  logic [W-1:0] cam_a [N];
  logic [W-1:0] cam_b [N];
  logic [W-1:0] cam_c [N];
  logic [N-1:0] ma, mb;
  logic [N-1:0] pa [3];
  logic [N-1:0] pb [3];

  always_comb begin
    ma = '0;
    mb = '0;
    for (int c = 0; c < N; c++) begin
      ma[c] = (((cam_a[c] ^ key_a_m) & mask_a_m) == '0);
      mb[c] = (((cam_b[c] ^ key_b_m) & mask_b_m) == '0);
    end
  end

  always @(posedge clk) begin
    pa[0] <= ma; pa[1] <= pa[0]; pa[2] <= pa[1];
    pb[0] <= mb; pb[1] <= pb[0]; pb[2] <= pb[1];
    for (int c = 0; c < N; c++) begin
      if (preload)       cam_c[c] <= preload_val;
      else if (wea_m[c]) cam_c[c] <= (cam_c[c] & ~mask_c_m) | (data_c_m & mask_c_m);
    end
  end

  assign tags_a = sel ? pa[2] : pa[0];
  assign tags_b = sel ? pb[2] : pb[0];

  typedef struct {
    logic [N*W-1:0] c;
    int             cycles;
    int             lat;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   pushes = 0;
  int   done_cnt = 0;
  int   busy_cnt = 0;
  int   wea_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_cell(input logic [3:0] t, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
    logic [W-1:0] r;
    for (int j = 0; j < W; j++) r[j] = t[int'(b[j]) * 2 + int'(a[j])];
    return r;
  endfunction

  // Monitor: times each busy window, checks wea placement, and pops on each done pulse.
  always @(negedge clk) begin
    if (busy_m) begin
      if (q.size() > 0) begin
        int p, k;
        p = 2 + q[0].lat;
        k = busy_cnt;
        if (k == 0) begin
          if (wea_m != '1) wea_bad++;
        end else if (!(k < q[0].cycles - 1 && (k - 1) % p == p - 1)) begin
          if (wea_m != '0) wea_bad++;
        end
      end
      busy_cnt++;
      if (done_m) begin
        done_cnt++;
        if (q.size() == 0) begin
          check("unexpected_done", 64'(done_m), 64'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("busy_cycles", 64'(busy_cnt), 64'(e.cycles));
          check("wea_timing_violations", 64'(wea_bad), 64'd0);
          for (int c = 0; c < N; c++) check($sformatf("cell_c%0d", c), 64'(cam_c[c]),
                                            64'(e.c[c*W +: W]));
        end
        busy_cnt = 0;
        wea_bad  = 0;
      end
    end else begin
      busy_cnt = 0;
      wea_bad  = 0;
      check("done_while_idle", 64'(done_m), 64'd0);
    end
  end

  task automatic check_idle(input string tag);
    #1;
    check({tag, "_busy"}, 64'(busy_m), 64'd0);
    check({tag, "_done"}, 64'(done_m), 64'd0);
    check({tag, "_cam_mode"}, 64'(cam_mode_m), 64'd0);
    check({tag, "_keys"}, 64'({key_a_m, key_b_m}), 64'd0);
    check({tag, "_masks"}, 64'({mask_a_m, mask_b_m, mask_c_m}), 64'hFF_FFFF);
    check({tag, "_data_c"}, 64'(data_c_m), 64'd0);
    check({tag, "_wea"}, 64'(wea_m), 64'd0);
  endtask

  task automatic push_expect(input bit s, input logic [3:0] t);
    exp_t e;
    e.lat    = s ? 3 : 1;
    e.cycles = 2 + W * $countones(t) * (2 + e.lat);
    for (int c = 0; c < N; c++) e.c[c*W +: W] = ref_cell(t, cam_a[c], cam_b[c]);
    q.push_back(e);
    pushes++;
  endtask

  task automatic issue(input bit s, input logic [3:0] t, input bit expect_result);
    @(posedge clk);
    #1;
    sel = s;
    if (expect_result) push_expect(s, t);
    tt = t;
    if (s) start1 = 1'b1;
    else   start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    start1 = 1'b0;
    tt     = 4'($urandom);
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 600 && !seen; n++) begin
      @(negedge clk);
      if (done_m) seen = 1'b1;
    end
    check("done_within_bound", 64'(seen), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_preload(input logic [W-1:0] v);
    @(posedge clk);
    #1;
    preload_val = v;
    preload     = 1'b1;
    @(posedge clk);
    #1;
    preload = 1'b0;
  endtask

  initial begin
    cam_a = '{8'h0F, 8'hF0, 8'hAA, 8'h00};
    cam_b = '{8'h33, 8'h0F, 8'h55, 8'h00};
    repeat (3) @(posedge clk);
    @(negedge clk);
    sel = 1'b0;
    check_idle("reset0");
    sel = 1'b1;
    check_idle("reset1");
    @(posedge clk);
    #1;
    rst = 1'b0;

    issue(1'b0, TT_OR, 1'b1);
    wait_done();
    issue(1'b0, TT_AND, 1'b1);
    wait_done();
    issue(1'b0, TT_XOR, 1'b1);
    wait_done();

    do_preload(8'hFF);
    issue(1'b0, 4'b0000, 1'b1);
    wait_done();

    // Second start mid-run must be ignored; monitor checks result and cycle count.
    issue(1'b0, TT_OR, 1'b1);
    repeat (8) @(posedge clk);
    #1;
    start0 = 1'b1;
    tt     = TT_AND;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    wait_done();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("idle_after_ignored_start", 64'(busy_m), 64'd0);

    // Reset on the 20th busy cycle of an OR run.
    issue(1'b0, TT_OR, 1'b0);
    repeat (18) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_idle("midrun_reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    issue(1'b0, TT_OR, 1'b1);
    wait_done();

    issue(1'b1, TT_NOR, 1'b1);
    wait_done();

    for (int r = 0; r < 8; r++) begin
      bit s;
      s = 1'($urandom);
      for (int c = 0; c < N; c++) begin
        cam_a[c] = 8'($urandom);
        cam_b[c] = 8'($urandom);
      end
      do_preload(8'($urandom));
      issue(s, 4'($urandom), 1'b1);
      wait_done();
    end

    repeat (5) @(posedge clk);
    @(negedge clk);
    check("done_pulse_count", 64'(done_cnt), 64'(pushes));
    check("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
